// File: rtl/mem_if_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mem_if_pkg;

    localparam int unsigned ADDR_BUS_W = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = 8 * WORD_BYTES;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Lowest byte-address bit that lies above the implemented word array.
    function automatic int unsigned addr_hi_lsb(input int unsigned addr_width);
        return addr_width + $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Single-port word RAM: synchronous write, synchronous read into a resettable output register.
module data_ram_array
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds its value unless a read is performed.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for MEM-stage data-memory requests: wait-state FSM, address checking
// and the backing word RAM.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_ren_i,
    input  logic                  data_wen_i,
    input  logic [ADDR_BUS_W-1:0] data_addr_i,
    input  logic [WORD_W-1:0]     data_din_i,
    output logic [WORD_W-1:0]     data_dout_o,
    output logic                  resp_valid_o,
    output logic                  stall_o,
    output logic                  addr_err_o
);

    localparam int unsigned      HI_LSB   = addr_hi_lsb(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             req_c;
    logic             err_c;
    logic             commit_c;
    logic             ram_en_c;

    assign req_c = data_ren_i || data_wen_i;
    assign err_c = (data_addr_i[1:0] != 2'b00) || ((data_addr_i >> HI_LSB) != '0);

    // Next state, wait counter, commit strobe and stall.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        commit_c = 1'b0;
        stall_o  = 1'b0;
        case (state)
            IDLE, RESP: begin
                state_n = IDLE;
                if (req_c) begin
                    if (WAIT_CYCLES == 0) begin
                        commit_c = 1'b1;
                        state_n  = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_LOAD;
                        stall_o = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_n   = cnt - CNT_ONE;
                    stall_o = 1'b1;
                end else begin
                    // Request dropped before the commit edge: nothing is committed.
                    commit_c = req_c;
                    state_n  = req_c ? RESP : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (!resetn) begin
            commit_c = 1'b0;
            stall_o  = 1'b0;
        end
    end

    // State register and one-cycle response flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            resp_valid_o <= 1'b0;
            addr_err_o   <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            resp_valid_o <= commit_c && !err_c && data_ren_i && !data_wen_i;
            addr_err_o   <= commit_c && err_c;
        end
    end

    assign ram_en_c = commit_c && !err_c;

    data_ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .resetn(resetn),
        .en    (ram_en_c),
        .we    (data_wen_i),
        .addr  (data_addr_i[ADDR_WIDTH+1:2]),
        .wdata (data_din_i),
        .rdata (data_dout_o)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder with WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_data_mem_responder;

    localparam int unsigned AW = 10;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, ren, wen, valid, stall, err;
    logic [31:0] addr, din, dout;
    logic        resetn0, ren0, wen0, valid0, stall0, err0;
    logic [31:0] addr0, din0, dout0;

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut (
        .clk(clk), .resetn(resetn), .data_ren_i(ren), .data_wen_i(wen),
        .data_addr_i(addr), .data_din_i(din), .data_dout_o(dout),
        .resp_valid_o(valid), .stall_o(stall), .addr_err_o(err)
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .resetn(resetn0), .data_ren_i(ren0), .data_wen_i(wen0),
        .data_addr_i(addr0), .data_din_i(din0), .data_dout_o(dout0),
        .resp_valid_o(valid0), .stall_o(stall0), .addr_err_o(err0)
    );

    typedef struct {
        int          cyc;
        logic        valid;
        logic        err;
        logic [31:0] dout;
    } exp_t;

    exp_t        q2[$];
    exp_t        q0[$];
    exp_t        e2, e0;
    logic [31:0] mem2 [int];
    logic [31:0] mem0 [int];
    logic [31:0] exp_dout2, exp_dout0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, act, exp);
        end
    endtask

    // Scoreboard for the wait-state instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q2.size() > 0 && q2[0].cyc == cyc) begin
                e2 = q2.pop_front();
                check("w2_valid", 32'(valid), 32'(e2.valid));
                check("w2_err", 32'(err), 32'(e2.err));
                check("w2_dout", dout, e2.dout);
            end else begin
                check("w2_idle_valid", 32'(valid), 32'd0);
                check("w2_idle_err", 32'(err), 32'd0);
            end
        end
    end

    // Scoreboard for the zero-wait instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q0.size() > 0 && q0[0].cyc == cyc) begin
                e0 = q0.pop_front();
                check("w0_valid", 32'(valid0), 32'(e0.valid));
                check("w0_err", 32'(err0), 32'(e0.err));
                check("w0_dout", dout0, e0.dout);
            end else begin
                check("w0_idle_valid", 32'(valid0), 32'd0);
                check("w0_idle_err", 32'(err0), 32'd0);
            end
        end
    end

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    endfunction

    // Full request on the WAIT_CYCLES=2 instance; returns in the response cycle.
    task automatic req2(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic e;
        logic [31:0] a_word;
        e      = addr_bad(a);
        a_word = a;
        ren = r; wen = w; addr = a; din = d;
        if (!e && w) mem2[int'(a_word[AW+1:2])] = d;
        else if (!e && r) exp_dout2 = mem2[int'(a_word[AW+1:2])];
        q2.push_back('{cyc + 3, !e && r && !w, e, exp_dout2});
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            check("w2_stall", 32'(stall), (c < 2) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        ren = 1'b0; wen = 1'b0;
    endtask

    // One back-to-back request on the WAIT_CYCLES=0 instance.
    task automatic req0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic e;
        logic [31:0] a_word;
        e      = addr_bad(a);
        a_word = a;
        ren0 = r; wen0 = w; addr0 = a; din0 = d;
        if (!e && w) mem0[int'(a_word[AW+1:2])] = d;
        else if (!e && r) exp_dout0 = mem0[int'(a_word[AW+1:2])];
        q0.push_back('{cyc + 1, !e && r && !w, e, exp_dout0});
        @(negedge clk);
        check("w0_stall", 32'(stall0), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        resetn = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; din = '0;
        resetn0 = 1'b0; ren0 = 1'b0; wen0 = 1'b0; addr0 = '0; din0 = '0;
        exp_dout2 = '0; exp_dout0 = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1; resetn0 = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_dout", dout, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_dout0", dout0, 32'd0);
        @(posedge clk); #1;

        // Preload 0x10, then reset with a write held and confirm RAM survives.
        req2(1'b0, 1'b1, 32'h10, 32'hCAFE_0010);
        resetn = 1'b0; wen = 1'b1; addr = 32'h10; din = 32'hBAD0_BAD0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_hold_stall", 32'(stall), 32'd0);
            if (c > 0) check("rst_hold_dout", dout, 32'd0);
            @(posedge clk); #1;
        end
        resetn = 1'b1; wen = 1'b0; exp_dout2 = '0;
        req2(1'b1, 1'b0, 32'h10, 32'h0);

        // Write then read back.
        req2(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        req2(1'b1, 1'b0, 32'h40, 32'h0);

        // Misaligned read; out-of-range write must not alias onto word 0.
        req2(1'b1, 1'b0, 32'h42, 32'h0);
        req2(1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5);
        req2(1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFF);
        req2(1'b1, 1'b0, 32'h0, 32'h0);
        req2(1'b1, 1'b0, 32'h0000_0FFC, 32'h0);

        // Simultaneous read and write: write wins.
        req2(1'b1, 1'b1, 32'hC, 32'h55);
        req2(1'b1, 1'b0, 32'hC, 32'h0);

        // Reset during WAIT drops the pending write.
        req2(1'b0, 1'b1, 32'h20, 32'h1234_5678);
        wen = 1'b1; addr = 32'h20; din = 32'h77;
        @(negedge clk);
        check("midrst_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b0; wen = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; exp_dout2 = '0;
        @(negedge clk);
        check("midrst_idle_stall", 32'(stall), 32'd0);
        check("midrst_dout", dout, 32'd0);
        @(posedge clk); #1;
        req2(1'b1, 1'b0, 32'h20, 32'h0);

        // Zero-wait back-to-back traffic, including read-after-write.
        req0(1'b0, 1'b1, 32'h8, 32'h11);
        req0(1'b1, 1'b0, 32'h8, 32'h0);
        req0(1'b0, 1'b1, 32'h8, 32'h22);
        req0(1'b1, 1'b0, 32'h8, 32'h0);
        req0(1'b1, 1'b0, 32'h6, 32'h0);
        req0(1'b1, 1'b0, 32'h8, 32'h0);
        ren0 = 1'b0; wen0 = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("sb_drain_w2", 32'(q2.size()), 32'd0);
        check("sb_drain_w0", 32'(q0.size()), 32'd0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
